vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
Sequencing FSM for the vending machine datapath. Consumes debounced keypad strobes and codes, accumulates credit, compares it against per-product prices, and drives the dispense pulse and change return. Sits between the debounced keypad output and the binary-to-BCD / seven-segment display path. Its credit output is the value shown on the display.

Parameters:
PRICE_A, 8'd15, price of product A (binary, units)
PRICE_B, 8'd20, price of product B
PRICE_C, 8'd35, price of product C
PRICE_D, 8'd50, price of product D
MAX_CREDIT, 8'd99, credit ceiling (display limit); all prices must be <= MAX_CREDIT
DISPENSE_CYCLES, 16'd4, cycles dispense is held high; must be >= 1

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high
key_valid  input  1  one-cycle strobe per debounced key press
key_code  input  4  key code, valid when key_valid=1
credit  output  8  current accumulated credit (binary)
dispense  output  1  product release, held DISPENSE_CYCLES cycles
product  output  2  selected product (0=A..3=D), stable while dispense=1
change  output  8  refund amount, valid when change_valid=1
change_valid  output  1  one-cycle change strobe
coin_reject  output  1  one-cycle pulse: coin refused (ceiling)
insufficient  output  1  one-cycle pulse: selection with too little credit
busy  output  1  high in VEND and CHANGE; keys are ignored while high

Behaviour:
- Key codes (package constants): 0x1 = coin 1, 0x2 = coin 2, 0x5 = coin 5, 0xA..0xD = select A..D, 0xE = cancel. All other codes are ignored with no pulse.
- Reset is synchronous and wins over everything, including mid-dispense. On reset: state=IDLE, credit=0, dispense=0, product=0, change=0, and change_valid, coin_reject, insufficient and busy all =0.
- All outputs are registered. A key strobed in cycle N produces its effect at cycle N+1.
- States: IDLE (credit=0), COLLECT (credit>0), VEND, CHANGE.
- Coin in IDLE or COLLECT:
  - if credit+value <= MAX_CREDIT: credit += value; state -> COLLECT.
  - otherwise: coin_reject=1 for one cycle; credit and state are unchanged.
  - Sum is computed 9 bits wide; no wrap-around is possible.
- Select in IDLE: insufficient pulse; no state change.
- Select in COLLECT:
  - if credit >= price[sel]: latch product=sel and an internal refund = credit - price; credit -> 0; dispense=1; state -> VEND.
  - else: insufficient pulse; credit unchanged.
  - credit == price is the exact boundary and vends with refund 0.
- Cancel in COLLECT: refund = credit; credit -> 0; state -> CHANGE. Cancel in IDLE: no effect.
- VEND: dispense held high for exactly DISPENSE_CYCLES cycles (cycles N+1..N+DISPENSE_CYCLES), then deasserts.
  - If refund != 0: -> CHANGE.
  - If refund = 0: -> IDLE.
- CHANGE: lasts one cycle with change=refund and change_valid=1, then -> IDLE. change returns to 0 in IDLE.
- busy=1 in VEND and CHANGE. key_valid there is dropped, with no pulse and no buffering.
- product holds its last value after vend; it is cleared only by reset.

Decomposition:
- Package vend_pkg holds:
  - key code localparams (KEY_COIN1, KEY_COIN2, KEY_COIN5, KEY_SEL_A..D, KEY_CANCEL);
  - coin value constants;
  - the state encoding (IDLE, COLLECT, VEND, CHANGE, 2 bits).
- One sub-module: vend_timer, a loadable down-counter. Load with DISPENSE_CYCLES, assert done at zero. Used for the dispense hold.
- Price selection is a case on sel inside the controller; it needs no separate module.

Test Plan:
- Reset mid-VEND (dispense=1) -> next cycle all outputs 0, state IDLE; a subsequent coin 0x5 gives credit=5.
- Coins 0x5,0x5,0x5,0x2 -> credit 5,10,15,17. Select A (0xA) -> next cycle credit=0, dispense=1, product=0 for 4 cycles. Then change_valid=1 with change=2 for one cycle, then IDLE.
- Credit 15, select A -> exact price. Dispense for 4 cycles, no change_valid, return to IDLE.
- Credit 10, select B (price 20) -> insufficient pulse, credit stays 10. Cancel (0xE) -> change=10, change_valid one cycle, credit=0.
- Credit 97, coin 0x5 -> coin_reject pulse, credit stays 97. Coin 0x2 -> credit 99. Coin 0x1 -> coin_reject.
- Coins and select pressed while busy=1 -> ignored: credit unchanged, no pulses. Unknown code 0x7 in COLLECT -> no effect.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared key codes, coin values and FSM state encoding for the vending controller.
package vend_pkg;

    localparam logic [3:0] KEY_COIN1  = 4'h1;
    localparam logic [3:0] KEY_COIN2  = 4'h2;
    localparam logic [3:0] KEY_COIN5  = 4'h5;
    localparam logic [3:0] KEY_SEL_A  = 4'hA;
    localparam logic [3:0] KEY_SEL_B  = 4'hB;
    localparam logic [3:0] KEY_SEL_C  = 4'hC;
    localparam logic [3:0] KEY_SEL_D  = 4'hD;
    localparam logic [3:0] KEY_CANCEL = 4'hE;

    localparam logic [7:0] COIN1_VAL = 8'd1;
    localparam logic [7:0] COIN2_VAL = 8'd2;
    localparam logic [7:0] COIN5_VAL = 8'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    // Zero means "not a coin key".
    function automatic logic [7:0] coin_value(input logic [3:0] code);
        case (code)
            KEY_COIN1: coin_value = COIN1_VAL;
            KEY_COIN2: coin_value = COIN2_VAL;
            KEY_COIN5: coin_value = COIN5_VAL;
            default:   coin_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// Keypad-in / status-out bundle between the debounced keypad and the vending controller.
interface vend_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] credit;
    logic       dispense;
    logic [1:0] product;
    logic [7:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;

    modport master (
        output key_valid, key_code,
        input  credit, dispense, product, change, change_valid,
               coin_reject, insufficient, busy
    );

    modport slave (
        input  key_valid, key_code,
        output credit, dispense, product, change, change_valid,
               coin_reject, insufficient, busy
    );
endinterface

// File: rtl/vend_timer.sv
// Loadable down-counter holding the dispense pulse; done is combinational on count==0.
// Load takes priority over decrement; no backpressure, counts only while en is high.
module vend_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: key strobe in cycle N takes effect at N+1, all outputs registered.
// No backpressure: keys arriving while busy (VEND/CHANGE) are silently dropped.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [7:0]  PRICE_A         = 8'd15,
    parameter logic [7:0]  PRICE_B         = 8'd20,
    parameter logic [7:0]  PRICE_C         = 8'd35,
    parameter logic [7:0]  PRICE_D         = 8'd50,
    parameter logic [7:0]  MAX_CREDIT      = 8'd99,
    parameter logic [15:0] DISPENSE_CYCLES = 16'd4
) (
    input  logic  clk,
    input  logic  reset,
    vend_if.slave bus
);
    state_t     state;
    logic [7:0] credit;
    logic [7:0] refund;
    logic       dispense;
    logic [1:0] product;
    logic [7:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;

    logic [7:0] coin_val;
    logic [8:0] coin_sum;
    logic [7:0] price;
    logic [1:0] sel;
    logic       take_key;
    logic       is_coin;
    logic       is_sel;
    logic       is_cancel;
    logic       vend_go;
    logic       timer_done;

    always_comb begin
        coin_val  = coin_value(bus.key_code);
        is_coin   = (coin_val != 8'd0);
        coin_sum  = {1'b0, credit} + {1'b0, coin_val};
        is_sel    = (bus.key_code >= KEY_SEL_A) && (bus.key_code <= KEY_SEL_D);
        is_cancel = (bus.key_code == KEY_CANCEL);
        sel       = 2'(bus.key_code - KEY_SEL_A);
        case (sel)
            2'd0:    price = PRICE_A;
            2'd1:    price = PRICE_B;
            2'd2:    price = PRICE_C;
            default: price = PRICE_D;
        endcase
        take_key = bus.key_valid && (state == IDLE || state == COLLECT);
        vend_go  = take_key && is_sel && (state == COLLECT) && (credit >= price);
    end

    // Loaded with one less than the hold length: the load cycle itself is the first dispense cycle.
    vend_timer #(.W(16)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (vend_go),
        .en       (state == VEND),
        .load_val (DISPENSE_CYCLES - 16'd1),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= 8'd0;
            refund       <= 8'd0;
            dispense     <= 1'b0;
            product      <= 2'd0;
            change       <= 8'd0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            change_valid <= 1'b0;
            change       <= 8'd0;
            case (state)
                IDLE, COLLECT: begin
                    if (take_key && is_coin) begin
                        if (coin_sum <= {1'b0, MAX_CREDIT}) begin
                            credit <= coin_sum[7:0];
                            state  <= COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (take_key && is_sel) begin
                        if (vend_go) begin
                            product  <= sel;
                            refund   <= credit - price;
                            credit   <= 8'd0;
                            dispense <= 1'b1;
                            busy     <= 1'b1;
                            state    <= VEND;
                        end else begin
                            insufficient <= 1'b1;
                        end
                    end else if (take_key && is_cancel && state == COLLECT) begin
                        change       <= credit;
                        change_valid <= 1'b1;
                        credit       <= 8'd0;
                        busy         <= 1'b1;
                        state        <= CHANGE;
                    end
                end
                VEND: begin
                    if (timer_done) begin
                        dispense <= 1'b0;
                        if (refund != 8'd0) begin
                            change       <= refund;
                            change_valid <= 1'b1;
                            state        <= CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                CHANGE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.credit       = credit;
    assign bus.dispense     = dispense;
    assign bus.product      = product;
    assign bus.change       = change;
    assign bus.change_valid = change_valid;
    assign bus.coin_reject  = coin_reject;
    assign bus.insufficient = insufficient;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed literal checks plus random keys against a frame-schedule model.
module tb_vend_controller;

    logic clk;
    logic reset;
    vend_if bus ();

    vend_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] credit;
        logic       dispense;
        logic [1:0] product;
        logic [7:0] change;
        logic       change_valid;
        logic       coin_reject;
        logic       insufficient;
        logic       busy;
    } frame_t;

    localparam int HOLD = 4;
    int price_tab [4] = '{15, 20, 35, 50};

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    endtask

    function automatic frame_t idle_f(input int c, input logic [1:0] p);
        frame_t f;
        f = '0;
        f.credit  = 8'(c);
        f.product = p;
        return f;
    endfunction

    // Model: credit as an integer, plus a queue of pre-computed busy frames per transaction.
    int     m_credit = 0;
    frame_t m_out    = '0;
    frame_t m_q [$];

    always @(posedge clk) begin
        frame_t nx;
        frame_t f;
        int     v;
        int     pr;
        int     rf;
        if (reset) begin
            m_q.delete();
            m_credit = 0;
            m_out    = '0;
        end else if (m_out.busy) begin
            if (m_q.size() > 0) m_out = m_q.pop_front();
            else                m_out = idle_f(m_credit, m_out.product);
        end else begin
            nx = idle_f(m_credit, m_out.product);
            if (bus.key_valid) begin
                v = (bus.key_code == 4'h1) ? 1 : (bus.key_code == 4'h2) ? 2 :
                    (bus.key_code == 4'h5) ? 5 : 0;
                if (v != 0) begin
                    if (m_credit + v <= 99) m_credit += v;
                    else                    nx.coin_reject = 1'b1;
                    nx.credit = 8'(m_credit);
                end else if (bus.key_code >= 4'hA && bus.key_code <= 4'hD) begin
                    pr = price_tab[int'(bus.key_code) - 10];
                    if (m_credit > 0 && m_credit >= pr) begin
                        rf = m_credit - pr;
                        m_credit = 0;
                        for (int i = 0; i < HOLD; i++) begin
                            f = '0;
                            f.dispense = 1'b1;
                            f.product  = 2'(int'(bus.key_code) - 10);
                            f.busy     = 1'b1;
                            m_q.push_back(f);
                        end
                        if (rf != 0) begin
                            f = '0;
                            f.product      = 2'(int'(bus.key_code) - 10);
                            f.change       = 8'(rf);
                            f.change_valid = 1'b1;
                            f.busy         = 1'b1;
                            m_q.push_back(f);
                        end
                        nx = m_q.pop_front();
                    end else begin
                        nx.insufficient = 1'b1;
                    end
                end else if (bus.key_code == 4'hE && m_credit > 0) begin
                    f = '0;
                    f.product      = m_out.product;
                    f.change       = 8'(m_credit);
                    f.change_valid = 1'b1;
                    f.busy         = 1'b1;
                    m_credit = 0;
                    nx = f;
                end
            end
            m_out = nx;
        end
    end

    always @(negedge clk) begin
        frame_t d;
        if (chk_en) begin
            d.credit       = bus.credit;
            d.dispense     = bus.dispense;
            d.product      = bus.product;
            d.change       = bus.change;
            d.change_valid = bus.change_valid;
            d.coin_reject  = bus.coin_reject;
            d.insufficient = bus.insufficient;
            d.busy         = bus.busy;
            check("cycle_frame", 32'(d), 32'(m_out));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        step(2);
        chk_en = 1;
        check("rst_credit", 32'(bus.credit), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        step(1);

        press(4'h5); check("coin_5", 32'(bus.credit), 32'd5);
        press(4'h5); check("coin_10", 32'(bus.credit), 32'd10);
        press(4'h5); check("coin_15", 32'(bus.credit), 32'd15);
        press(4'h2); check("coin_17", 32'(bus.credit), 32'd17);
        press(4'hA);
        check("vendA_credit", 32'(bus.credit), 32'd0);
        check("vendA_disp", 32'(bus.dispense), 32'd1);
        check("vendA_prod", 32'(bus.product), 32'd0);
        step(3); check("vendA_disp4", 32'(bus.dispense), 32'd1);
        step(1);
        check("vendA_disp_off", 32'(bus.dispense), 32'd0);
        check("vendA_cv", 32'(bus.change_valid), 32'd1);
        check("vendA_change", 32'(bus.change), 32'd2);
        step(1);
        check("vendA_cv_off", 32'(bus.change_valid), 32'd0);
        check("vendA_idle", 32'(bus.busy), 32'd0);

        repeat (3) press(4'h5);
        press(4'hA);
        step(3); check("exact_disp4", 32'(bus.dispense), 32'd1);
        step(1);
        check("exact_no_cv", 32'(bus.change_valid), 32'd0);
        check("exact_idle", 32'(bus.busy), 32'd0);

        press(4'h5); press(4'h5);
        press(4'hB);
        check("insuf_pulse", 32'(bus.insufficient), 32'd1);
        check("insuf_credit", 32'(bus.credit), 32'd10);
        step(1);
        press(4'hE);
        check("cancel_change", 32'(bus.change), 32'd10);
        check("cancel_cv", 32'(bus.change_valid), 32'd1);
        check("cancel_credit", 32'(bus.credit), 32'd0);
        step(1);

        repeat (19) press(4'h5);
        press(4'h2); check("ceil_97", 32'(bus.credit), 32'd97);
        press(4'h5);
        check("ceil_reject", 32'(bus.coin_reject), 32'd1);
        check("ceil_keep", 32'(bus.credit), 32'd97);
        press(4'h2); check("ceil_99", 32'(bus.credit), 32'd99);
        press(4'h1); check("ceil_reject2", 32'(bus.coin_reject), 32'd1);
        press(4'hE); step(1);

        repeat (5) press(4'h5);
        press(4'hB);
        press(4'h5); press(4'hA); press(4'hE);
        step(1); check("busy_change", 32'(bus.change), 32'd5);
        step(1);
        check("busy_credit", 32'(bus.credit), 32'd0);
        check("prod_hold", 32'(bus.product), 32'd1);
        press(4'h5); press(4'h7);
        check("unknown_credit", 32'(bus.credit), 32'd5);
        press(4'hE); step(1);

        repeat (7) press(4'h5);
        press(4'hC);
        check("vendC_prod", 32'(bus.product), 32'd2);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_disp", 32'(bus.dispense), 32'd0);
        check("midrst_prod", 32'(bus.product), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        press(4'h5); check("midrst_coin", 32'(bus.credit), 32'd5);

        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 499) == 0);
            bus.key_valid = ($urandom_range(0, 2) != 0);
            bus.key_code  = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'($urandom_range(0, 15));
            step(1);
        end
        reset         = 1'b0;
        bus.key_valid = 1'b0;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
